// File: rtl/im_responder_if.sv
// im_responder_if: fetch handshake and load-port bundle between the fetch unit
// (master) and the instruction-memory responder (slave).
//   Req/Addr          fetch request, held with Addr stable until Ack
//   Ack/Instr/AddrErr one-cycle response strobe, instruction, address error
//   Busy              responder not idle
//   WE/WAddr/WData    load-port word write
interface im_responder_if;
  logic        Req;
  logic [31:0] Addr;
  logic        Ack;
  logic [31:0] Instr;
  logic        AddrErr;
  logic        Busy;
  logic        WE;
  logic [9:0]  WAddr;
  logic [31:0] WData;

  modport master (output Req, Addr, WE, WAddr, WData,
                  input  Ack, Instr, AddrErr, Busy);
  modport slave  (input  Req, Addr, WE, WAddr, WData,
                  output Ack, Instr, AddrErr, Busy);
endinterface

// File: rtl/im_responder.sv
// im_responder: instruction-memory responder for the CPU fetch interface.
// Accepts a word fetch in IDLE, waits WAIT_CYCLES, then raises Ack for one
// cycle with the instruction (or Instr=0/AddrErr=1 for a misaligned or
// out-of-window address). A load port writes the 1024x32 array in any state.
//
// Ports:
//   Clk    clock, rising edge
//   Reset  asynchronous active-low reset
//   bus    im_responder_if.slave (Req/Addr/Ack/Instr/AddrErr/Busy/WE/WAddr/WData)
//
// Parameters: WAIT_CYCLES (0..15), BASE_ADDR (byte address of word 0).
//
// Optional feature macro: IM_PREFETCH_EN -- one-entry next-line buffer that
// lets a fetch of the word following the previous response complete in one
// cycle. Without it every fetch takes WAIT_CYCLES+1 cycles.
module im_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000
) (
  input logic           Clk,
  input logic           Reset,
  im_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] WIN_SIZE  = 32'h0000_1000;

  logic [31:0] r_mem [1024];

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_ack;
  logic        r_err;
  logic        r_busy;
  logic [31:0] r_instr;

  // Capture address: the live bus address when capturing straight out of
  // IDLE (WAIT_CYCLES=0), otherwise the latched one.
  logic [31:0] w_cap_addr;
  logic [31:0] w_cap_off;
  logic        w_cap_ok;
  logic [9:0]  w_cap_idx;
  logic [31:0] w_cap_word;
  logic [31:0] w_cap_instr;

  assign w_cap_addr  = (r_state == IDLE) ? bus.Addr : r_addr;
  assign w_cap_off   = w_cap_addr - BASE_ADDR;  // wraps high when below window
  assign w_cap_ok    = (w_cap_addr[1:0] == 2'b00) && (w_cap_off < WIN_SIZE);
  assign w_cap_idx   = w_cap_off[11:2];
  // Write-first: a same-edge load-port write to the captured word wins.
  assign w_cap_word  = (bus.WE && (bus.WAddr == w_cap_idx)) ? bus.WData
                                                             : r_mem[w_cap_idx];
  assign w_cap_instr = w_cap_ok ? w_cap_word : 32'h0;

  // Array contents survive reset.
  always_ff @(posedge Clk) begin
    if (bus.WE) r_mem[bus.WAddr] <= bus.WData;
  end

`ifdef IM_PREFETCH_EN
  logic        r_pf_vld;
  logic [31:0] r_pf_tag;
  logic [31:0] r_pf_data;
  logic [31:0] w_nxt_addr;
  logic [31:0] w_nxt_off;
  logic        w_nxt_ok;
  logic [9:0]  w_nxt_idx;
  logic        w_pf_hit;
  logic [31:0] w_pf_data;

  assign w_nxt_addr = r_addr + 32'd4;
  assign w_nxt_off  = w_nxt_addr - BASE_ADDR;
  assign w_nxt_ok   = (w_nxt_off < WIN_SIZE);
  assign w_nxt_idx  = w_nxt_off[11:2];
  // A same-edge write could target the buffered word, so it blocks the hit.
  assign w_pf_hit   = r_pf_vld && !bus.WE && (bus.Addr == r_pf_tag);
  assign w_pf_data  = r_pf_data;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pf_vld  <= 1'b0;
      r_pf_tag  <= '0;
      r_pf_data <= '0;
    end else if (bus.WE) begin
      r_pf_vld  <= 1'b0;
    end else if (r_state == RESP && !r_err) begin
      // r_addr is aligned here, so only the window edge can reject Addr+4.
      r_pf_vld  <= w_nxt_ok;
      r_pf_tag  <= w_nxt_addr;
      r_pf_data <= r_mem[w_nxt_idx];
    end
  end
`else
  logic        w_pf_hit;
  logic [31:0] w_pf_data;
  assign w_pf_hit  = 1'b0;
  assign w_pf_data = 32'h0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_instr <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Req) begin
            r_addr <= bus.Addr;
            r_busy <= 1'b1;
            if (w_pf_hit) begin
              r_state <= RESP;
              r_ack   <= 1'b1;
              r_instr <= w_pf_data;
              r_err   <= 1'b0;
            end else if (WAIT_INIT == 4'd0) begin
              r_state <= RESP;
              r_ack   <= 1'b1;
              r_instr <= w_cap_instr;
              r_err   <= !w_cap_ok;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
            r_ack   <= 1'b1;
            r_instr <= w_cap_instr;
            r_err   <= !w_cap_ok;
          end
        end
        RESP: begin
          // Req is ignored here, so a Req still held from this fetch is not
          // accepted again until the following IDLE edge.
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.Ack     = r_ack;
  assign bus.Instr   = r_instr;
  assign bus.AddrErr = r_err;
  assign bus.Busy    = r_busy;

endmodule

// File: tb/tb_im_responder.sv
// tb_im_responder: scoreboard bench for im_responder. Each fetch pushes its
// expected instruction, error flag and Ack cycle; a negedge monitor pops and
// compares on every Ack. An Ack with an empty scoreboard is a failure.
module tb_im_responder;
  localparam int          WAITC = 2;
  localparam logic [31:0] BASE  = 32'h0000_3000;
`ifdef IM_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          cyc;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  // bench-side view of memory and the next-line buffer
  logic [31:0] m_mem [1024];
  bit          m_vld = 1'b0;
  logic [31:0] m_tag = '0;

  im_responder_if bus();

  im_responder #(.WAIT_CYCLES(WAITC), .BASE_ADDR(BASE)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a <= BASE + 32'h0000_0FFF);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) >> 2;
    return m_mem[idx[9:0]];
  endfunction

  task automatic wr(input logic [9:0] i, input logic [31:0] d);
    bus.WE = 1'b1; bus.WAddr = i; bus.WData = d;
    @(negedge Clk);
    bus.WE = 1'b0;
    m_mem[i] = d;
    m_vld = 1'b0;
  endtask

  // Called at a negedge; acc is the number of edges until acceptance
  // (1 from IDLE, 2 when Req is held through the previous RESP cycle).
  task automatic fetch(input logic [31:0] a, input logic [31:0] ei,
                       input int acc, input bit hold);
    exp_t e;
    int   c0, n;
    bit   hit;
    hit     = PF && m_vld && (a == m_tag);
    c0      = cyc;
    e.instr = in_win(a) ? ei : 32'h0;
    e.err   = !in_win(a);
    e.cyc   = c0 + acc + (hit ? 0 : WAITC);
    q.push_back(e);
    bus.Req = 1'b1; bus.Addr = a;
    n = 0;
    forever begin
      @(negedge Clk);
      n++;
      if (cyc == c0 + acc) chk("busy_hi", 32'(bus.Busy), 32'd1);
      if (bus.Ack) break;
      if (n > 40) begin
        chk("ack_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (!hold) begin
      bus.Req = 1'b0;
      @(negedge Clk);
      chk("ack_1cyc", 32'(bus.Ack), 32'd0);
      chk("busy_lo", 32'(bus.Busy), 32'd0);
    end
    if (in_win(a)) begin
      m_vld = in_win(a + 32'd4);
      m_tag = a + 32'd4;
    end
  endtask

  always @(negedge Clk) begin
    if (Reset && bus.Ack) begin
      if (q.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("instr", bus.Instr, e.instr);
        chk("addr_err", 32'(bus.AddrErr), 32'(e.err));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Req = 1'b0; bus.Addr = '0; bus.WE = 1'b0; bus.WAddr = '0; bus.WData = '0;
    repeat (3) @(negedge Clk);
    chk("rst_ack", 32'(bus.Ack), 32'd0);
    chk("rst_instr", bus.Instr, 32'h0);
    chk("rst_err", 32'(bus.AddrErr), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    wr(10'd0, 32'h3C01_1234);
    wr(10'd1, 32'h2402_0001);
    wr(10'd2, 32'h0000_0002);
    wr(10'd5, 32'h1111_1111);
    wr(10'd1023, 32'hDEAD_BEEF);

    // basic fetch, misaligned, out of window (above and below)
    fetch(32'h0000_3000, word_at(32'h0000_3000), 1, 1'b0);
    fetch(32'h0000_3002, 32'h0, 1, 1'b0);
    fetch(32'h0000_4000, 32'h0, 1, 1'b0);
    fetch(32'h0000_2FFC, 32'h0, 1, 1'b0);

    // Req held across Ack for two consecutive words
    fetch(32'h0000_3000, word_at(32'h0000_3000), 1, 1'b1);
    fetch(32'h0000_3004, word_at(32'h0000_3004), 2, 1'b0);
    repeat (4) @(negedge Clk);

    // reset in the middle of WAIT drops the request
    bus.Req = 1'b1; bus.Addr = 32'h0000_3008;
    @(negedge Clk);
    Reset = 1'b0; bus.Req = 1'b0;
    @(negedge Clk);
    chk("midrst_ack", 32'(bus.Ack), 32'd0);
    chk("midrst_instr", bus.Instr, 32'h0);
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    Reset = 1'b1;
    m_vld = 1'b0;
    repeat (5) @(negedge Clk);
    chk("midrst_noack_instr", bus.Instr, 32'h0);
    fetch(32'h0000_3008, word_at(32'h0000_3008), 1, 1'b0);

    // load-port write to the captured word on the capture edge
    wr(10'd5, 32'h2222_2222);
    fork
      fetch(32'h0000_3014, 32'hA5A5_5A5A, 1, 1'b0);
      begin
        repeat (WAITC) @(negedge Clk);
        wr(10'd5, 32'hA5A5_5A5A);
      end
    join

    // last word of the window, then the first word past it
    fetch(32'h0000_3FFC, word_at(32'h0000_3FFC), 1, 1'b0);
    fetch(32'h0000_4000, 32'h0, 1, 1'b0);

    // sequential pair with a write in between, then without
    fetch(32'h0000_3000, word_at(32'h0000_3000), 1, 1'b0);
    wr(10'd1, 32'h2402_0077);
    fetch(32'h0000_3004, word_at(32'h0000_3004), 1, 1'b0);
    fetch(32'h0000_3008, word_at(32'h0000_3008), 1, 1'b0);

    repeat (4) @(negedge Clk);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
